morse_letter_decoder: RTL and testbench

//  Receive-side counterpart of the LED Morse sender. Times presses of a single

---
 rtl/morse_letter_decoder.sv | 182 ++++++++++++++++++
 tb/tb_morse_letter_decoder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/morse_letter_decoder.sv
// Purpose: times a single Morse key, classifies marks as dot/dash and decodes letters A-H onto HEX0.
// Latency: 2-cycle input synchronizer; result pulse one cycle after the gap-ending tick.
// Backpressure: none; letter_valid/letter_err are single-cycle pulses with no handshake.
module morse_letter_decoder #(
  parameter int UNIT_CYCLES    = 16777216,
  parameter int DASH_MIN_UNITS = 2,
  parameter int GAP_UNITS      = 3
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       key_in,
  output logic       letter_valid,
  output logic       letter_err,
  output logic [2:0] letter_code,
  output logic [2:0] symbol_count,
  output logic       busy,
  output logic [6:0] HEX0
);

  localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] PRE_LAST = CW'(UNIT_CYCLES - 1);
  localparam logic [3:0] DASH_MIN = 4'(DASH_MIN_UNITS);
  localparam logic [3:0] GAP_LAST = 4'(GAP_UNITS - 1);
  localparam logic [6:0] BLANK    = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    EMIT  = 2'd3
  } state_t;

  state_t        state;
  logic          sync_1;
  logic          k;
  logic          k_d;
  logic [CW-1:0] pre_cnt;
  logic [3:0]    units;
  logic [3:0]    pat;
  logic          overflow;

  logic rise;
  logic fall;
  logic key_edge;
  logic tick;
  logic unit_tick;
  logic dash;

  logic       dec_ok;
  logic [2:0] dec_code;
  logic [6:0] dec_hex;

  assign rise      = k & ~k_d;
  assign fall      = ~k & k_d;
  assign key_edge  = rise | fall;
  assign tick      = (pre_cnt == PRE_LAST);
  // A key edge restarts timing, so a coincident tick must not count.
  assign unit_tick = tick & ~key_edge;
  assign dash      = (units >= DASH_MIN);

  // Two-flop synchronizer plus a delayed copy for edge detection.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync_1 <= 1'b0;
      k      <= 1'b0;
      k_d    <= 1'b0;
    end else begin
      sync_1 <= key_in;
      k      <= sync_1;
      k_d    <= k;
    end
  end

  // Unit prescaler, realigned to every key edge so units count from the edge.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      pre_cnt <= '0;
    end else if (key_edge || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Completed-unit counter for the current mark or space, saturating at 15.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      units <= 4'd0;
    end else if (key_edge) begin
      units <= 4'd0;
    end else if (unit_tick && (units != 4'd15)) begin
      units <= units + 4'd1;
    end
  end

  // Letter lookup on the captured symbol count and pattern (dot=0, dash=1).
  always_comb begin
    dec_ok   = 1'b1;
    dec_code = 3'd0;
    dec_hex  = BLANK;
    case ({symbol_count, pat})
      {3'd2, 4'b0001}: begin dec_code = 3'd0; dec_hex = 7'b0001000; end
      {3'd4, 4'b1000}: begin dec_code = 3'd1; dec_hex = 7'b0000000; end
      {3'd4, 4'b1010}: begin dec_code = 3'd2; dec_hex = 7'b1000110; end
      {3'd3, 4'b0100}: begin dec_code = 3'd3; dec_hex = 7'b1000000; end
      {3'd1, 4'b0000}: begin dec_code = 3'd4; dec_hex = 7'b0000110; end
      {3'd4, 4'b0010}: begin dec_code = 3'd5; dec_hex = 7'b0001110; end
      {3'd3, 4'b0110}: begin dec_code = 3'd6; dec_hex = 7'b1000010; end
      {3'd4, 4'b0000}: begin dec_code = 3'd7; dec_hex = 7'b0001001; end
      default:         dec_ok = 1'b0;
    endcase
  end

  // Letter FSM with registered pulses, display and status outputs.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state        <= IDLE;
      pat          <= 4'd0;
      overflow     <= 1'b0;
      symbol_count <= 3'd0;
      letter_valid <= 1'b0;
      letter_err   <= 1'b0;
      letter_code  <= 3'd0;
      busy         <= 1'b0;
      HEX0         <= BLANK;
    end else begin
      letter_valid <= 1'b0;
      letter_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state        <= MARK;
            busy         <= 1'b1;
            pat          <= 4'd0;
            symbol_count <= 3'd0;
            overflow     <= 1'b0;
          end
        end
        MARK: begin
          if (fall) begin
            state <= SPACE;
            busy  <= 1'b1;
            // A fifth symbol cannot fit; remember it so the letter is rejected.
            if (symbol_count == 3'd4) begin
              overflow <= 1'b1;
            end else begin
              pat          <= {pat[2:0], dash};
              symbol_count <= symbol_count + 3'd1;
            end
          end
        end
        SPACE: begin
          if (rise) begin
            state <= MARK;
            busy  <= 1'b1;
          end else if (unit_tick && (units == GAP_LAST)) begin
            state <= EMIT;
            busy  <= 1'b0;
          end
        end
        EMIT: begin
          // Any rise seen here is dropped; a fresh press is needed from IDLE.
          state <= IDLE;
          busy  <= 1'b0;
          if (dec_ok && !overflow) begin
            letter_valid <= 1'b1;
            letter_code  <= dec_code;
            HEX0         <= dec_hex;
          end else begin
            letter_err <= 1'b1;
            HEX0       <= BLANK;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_letter_decoder.sv
// Purpose: self-checking bench for morse_letter_decoder with a short time unit.
// Latency: expected letter results are queued at stimulus time and matched on each output pulse.
// Backpressure: none; the bench only drives the key and observes pulses.
`timescale 1ns/1ps
module tb_morse_letter_decoder;

  typedef struct packed {
    logic       v;
    logic       e;
    logic [2:0] code;
    logic [6:0] hex;
  } res_t;

  localparam logic [6:0] BLANK = 7'b1111111;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       key_in = 1'b0;
  logic       letter_valid;
  logic       letter_err;
  logic [2:0] letter_code;
  logic [2:0] symbol_count;
  logic       busy;
  logic [6:0] HEX0;

  int   n_checks = 0;
  int   n_pass = 0;
  res_t exp_q[$];
  logic [2:0] model_code = 3'd0;

  morse_letter_decoder #(
    .UNIT_CYCLES(4),
    .DASH_MIN_UNITS(2),
    .GAP_UNITS(3)
  ) dut (
    .CLOCK_50(clk),
    .RESET(RESET),
    .key_in(key_in),
    .letter_valid(letter_valid),
    .letter_err(letter_err),
    .letter_code(letter_code),
    .symbol_count(symbol_count),
    .busy(busy),
    .HEX0(HEX0)
  );

  always #5 clk = ~clk;

  // Scoreboard: every result pulse must match the oldest expected entry.
  always @(negedge clk) begin
    res_t got;
    res_t want;
    if (!RESET && (letter_valid || letter_err)) begin
      got = {letter_valid, letter_err, letter_code, HEX0};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_pulse: got v=%0b e=%0b code=%0d hex=%b, none expected",
                 got.v, got.e, got.code, got.hex);
      end else begin
        want = exp_q.pop_front();
        if (got !== want)
          $display("FAIL letter_result: got v=%0b e=%0b code=%0d hex=%b, want v=%0b e=%0b code=%0d hex=%b",
                   got.v, got.e, got.code, got.hex, want.v, want.e, want.code, want.hex);
        else
          n_pass++;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sym(input int press, input int rel);
    key_in = 1'b1;
    cycles(press);
    key_in = 1'b0;
    cycles(rel);
  endtask

  task automatic expect_valid(input logic [2:0] code, input logic [6:0] hex);
    exp_q.push_back({1'b1, 1'b0, code, hex});
    model_code = code;
  endtask

  task automatic expect_err();
    exp_q.push_back({1'b0, 1'b1, model_code, BLANK});
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    key_in = 1'b0;
    cycles(3);
    n_checks++; if (HEX0 !== BLANK) $display("FAIL reset_hex: got %b want %b", HEX0, BLANK); else n_pass++;
    n_checks++; if (letter_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", letter_valid); else n_pass++;
    n_checks++; if (letter_err !== 1'b0) $display("FAIL reset_err: got %b want 0", letter_err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (symbol_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", symbol_count); else n_pass++;
    n_checks++; if (letter_code !== 3'd0) $display("FAIL reset_code: got %0d want 0", letter_code); else n_pass++;
    RESET = 1'b0;
    model_code = 3'd0;
    cycles(4);
  endtask

  task automatic test_letter_a();
    expect_valid(3'd0, 7'b0001000);
    key_in = 1'b1;
    cycles(6);
    key_in = 1'b0;
    cycles(4);
    n_checks++; if (busy !== 1'b1) $display("FAIL a_busy_gap: got %b want 1", busy); else n_pass++;
    n_checks++; if (symbol_count !== 3'd1) $display("FAIL a_count_gap: got %0d want 1", symbol_count); else n_pass++;
    cycles(4);
    sym(12, 20);
    cycles(10);
    n_checks++; if (exp_q.size() != 0) $display("FAIL a_missing: got %0d pending want 0", exp_q.size()); else n_pass++;
    exp_q.delete();
    n_checks++; if (busy !== 1'b0) $display("FAIL a_busy_end: got %b want 0", busy); else n_pass++;
    n_checks++; if (HEX0 !== 7'b0001000) $display("FAIL a_hex_hold: got %b want 0001000", HEX0); else n_pass++;
  endtask

  task automatic test_letter_h();
    expect_valid(3'd7, 7'b0001001);
    for (int i = 0; i < 4; i++) sym(6, 8);
    cycles(20);
    cycles(10);
    n_checks++; if (exp_q.size() != 0) $display("FAIL h_missing: got %0d pending want 0", exp_q.size()); else n_pass++;
    exp_q.delete();
    n_checks++; if (letter_code !== 3'd7) $display("FAIL h_code_hold: got %0d want 7", letter_code); else n_pass++;
  endtask

  task automatic test_overflow();
    expect_err();
    for (int i = 0; i < 5; i++) sym(6, 8);
    cycles(20);
    cycles(10);
    n_checks++; if (exp_q.size() != 0) $display("FAIL ovf_missing: got %0d pending want 0", exp_q.size()); else n_pass++;
    exp_q.delete();
    n_checks++; if (HEX0 !== BLANK) $display("FAIL ovf_hex: got %b want %b", HEX0, BLANK); else n_pass++;
    n_checks++; if (letter_code !== 3'd7) $display("FAIL ovf_code: got %0d want 7", letter_code); else n_pass++;
  endtask

  task automatic test_unknown_and_abort();
    // "--.." has a legal length but is not one of A-H.
    expect_err();
    sym(12, 8);
    sym(12, 8);
    sym(6, 8);
    sym(6, 20);
    cycles(10);
    n_checks++; if (exp_q.size() != 0) $display("FAIL unk_missing: got %0d pending want 0", exp_q.size()); else n_pass++;
    exp_q.delete();
    n_checks++; if (letter_code !== 3'd7) $display("FAIL unk_code: got %0d want 7", letter_code); else n_pass++;
    // Two symbols, then reset inside the gap: nothing may be reported.
    sym(6, 8);
    sym(12, 6);
    RESET = 1'b1;
    cycles(2);
    RESET = 1'b0;
    model_code = 3'd0;
    cycles(1);
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (symbol_count !== 3'd0) $display("FAIL abort_count: got %0d want 0", symbol_count); else n_pass++;
    n_checks++; if (letter_code !== 3'd0) $display("FAIL abort_code: got %0d want 0", letter_code); else n_pass++;
    cycles(25);
    expect_valid(3'd4, 7'b0000110);
    sym(6, 20);
    cycles(10);
    n_checks++; if (exp_q.size() != 0) $display("FAIL e_missing: got %0d pending want 0", exp_q.size()); else n_pass++;
    exp_q.delete();
    n_checks++; if (letter_code !== 3'd4) $display("FAIL e_code_hold: got %0d want 4", letter_code); else n_pass++;
  endtask

  task automatic test_long_dash();
    expect_valid(3'd6, 7'b1000010);
    key_in = 1'b1;
    cycles(100);
    n_checks++; if (busy !== 1'b1) $display("FAIL g_busy_hold: got %b want 1", busy); else n_pass++;
    key_in = 1'b0;
    cycles(8);
    sym(100, 8);
    sym(6, 20);
    cycles(10);
    n_checks++; if (exp_q.size() != 0) $display("FAIL g_missing: got %0d pending want 0", exp_q.size()); else n_pass++;
    exp_q.delete();
    n_checks++; if (HEX0 !== 7'b1000010) $display("FAIL g_hex_hold: got %b want 1000010", HEX0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_letter_a();
    test_letter_h();
    test_overflow();
    test_unknown_and_abort();
    test_long_dash();
    cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
